// File: rtl/regfile_scoreboard.sv
// Register file with two registered read ports, write-first bypass and a
// per-register pending-write scoreboard used by decode for RAW detection.
module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        wb_index,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_write,
    input  logic              issue_valid,
    input  logic [4:0]        issue_index,
    output logic              issue_ready,
    input  logic [4:0]        rd_addr_a,
    input  logic [4:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    output logic              wb_unexpected
);

    localparam logic [PEND_W-1:0] CNT_MAX  = '1;
    localparam logic [PEND_W-1:0] CNT_ZERO = '0;
    localparam logic [PEND_W-1:0] CNT_ONE  = PEND_W'(1);

    logic [DATA_W-1:0] r_regs [32];
    logic [PEND_W-1:0] r_cnt  [32];
    logic [DATA_W-1:0] r_rdDataA;
    logic [DATA_W-1:0] r_rdDataB;
    logic              r_rdBusyA;
    logic              r_rdBusyB;
    logic              r_wbUnexpected;

    logic [PEND_W-1:0] w_cntNext [32];
    logic              w_issueFire;
    logic              w_wbLive;
    logic              w_wbUnexpected;

    // A saturated counter refuses the issue; a same-cycle retire does not help.
    assign issue_ready    = (issue_index == 5'd0) || (r_cnt[issue_index] != CNT_MAX);
    assign w_issueFire    = issue_valid && issue_ready && (issue_index != 5'd0);
    assign w_wbLive       = wb_write && (wb_index != 5'd0);
    assign w_wbUnexpected = w_wbLive && (r_cnt[wb_index] == CNT_ZERO)
                            && !(w_issueFire && (issue_index == wb_index));

    assign rd_data_a     = r_rdDataA;
    assign rd_data_b     = r_rdDataB;
    assign rd_busy_a     = r_rdBusyA;
    assign rd_busy_b     = r_rdBusyB;
    assign wb_unexpected = r_wbUnexpected;

    // Next pending count per register: inc on accepted issue, dec on retire, both cancel.
    always_comb begin
        w_cntNext[0] = CNT_ZERO;
        for (int r = 1; r < 32; r++) begin
            w_cntNext[r] = r_cnt[r];
            if ((w_issueFire && (issue_index == 5'(r))) &&
                !(wb_write && (wb_index == 5'(r)) && (r_cnt[r] != CNT_ZERO))) begin
                w_cntNext[r] = r_cnt[r] + CNT_ONE;
            end else if (!(w_issueFire && (issue_index == 5'(r))) &&
                         (wb_write && (wb_index == 5'(r)) && (r_cnt[r] != CNT_ZERO))) begin
                w_cntNext[r] = r_cnt[r] - CNT_ONE;
            end
        end
    end

    // Register array, scoreboard, registered read ports and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                r_regs[r] <= '0;
                r_cnt[r]  <= CNT_ZERO;
            end
            r_rdDataA      <= '0;
            r_rdDataB      <= '0;
            r_rdBusyA      <= 1'b0;
            r_rdBusyB      <= 1'b0;
            r_wbUnexpected <= 1'b0;
        end else begin
            if (w_wbLive) begin
                r_regs[wb_index] <= wb_data;
            end
            for (int r = 0; r < 32; r++) begin
                r_cnt[r] <= w_cntNext[r];
            end

            if (rd_addr_a == 5'd0) begin
                r_rdDataA <= '0;
            end else if (wb_write && (wb_index == rd_addr_a)) begin
                r_rdDataA <= wb_data;
            end else begin
                r_rdDataA <= r_regs[rd_addr_a];
            end

            if (rd_addr_b == 5'd0) begin
                r_rdDataB <= '0;
            end else if (wb_write && (wb_index == rd_addr_b)) begin
                r_rdDataB <= wb_data;
            end else begin
                r_rdDataB <= r_regs[rd_addr_b];
            end

            r_rdBusyA <= (rd_addr_a != 5'd0) && (w_cntNext[rd_addr_a] != CNT_ZERO);
            r_rdBusyB <= (rd_addr_b != 5'd0) && (w_cntNext[rd_addr_b] != CNT_ZERO);

            if (w_wbUnexpected) begin
                r_wbUnexpected <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed testbench for regfile_scoreboard: reset, bypass, scoreboard
// saturation, simultaneous issue/retire, register 0, sticky error, mid-run reset.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic [4:0]  wb_index;
    logic [31:0] wb_data;
    logic        wb_write;
    logic        issue_valid;
    logic [4:0]  issue_index;
    logic        issue_ready;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        rd_busy_a;
    logic        rd_busy_b;
    logic        wb_unexpected;

    int checks = 0;
    int errors = 0;

    regfile_scoreboard #(.DATA_W(32), .PEND_W(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_index      (wb_index),
        .wb_data       (wb_data),
        .wb_write      (wb_write),
        .issue_valid   (issue_valid),
        .issue_index   (issue_index),
        .issue_ready   (issue_ready),
        .rd_addr_a     (rd_addr_a),
        .rd_addr_b     (rd_addr_b),
        .rd_data_a     (rd_data_a),
        .rd_data_b     (rd_data_b),
        .rd_busy_a     (rd_busy_a),
        .rd_busy_b     (rd_busy_b),
        .wb_unexpected (wb_unexpected)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the given number of rising edges, settling 1 unit after the last.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Linear directed sequence of steps.
    initial begin
        rst = 1'b1; wb_index = '0; wb_data = '0; wb_write = 1'b0;
        issue_valid = 1'b0; issue_index = '0; rd_addr_a = '0; rd_addr_b = '0;
        applyStimulus(2);
        rst = 1'b0;

        // Reset state and reads of 0 and 5.
        rd_addr_a = 5'd0; rd_addr_b = 5'd5;
        checkOutput("ready_idx0", {31'b0, issue_ready}, 32'd1);
        applyStimulus(1);
        checkOutput("rst_data_a", rd_data_a, 32'd0);
        checkOutput("rst_data_b", rd_data_b, 32'd0);
        checkOutput("rst_busy_a", {31'b0, rd_busy_a}, 32'd0);
        checkOutput("rst_busy_b", {31'b0, rd_busy_b}, 32'd0);
        checkOutput("rst_unexp", {31'b0, wb_unexpected}, 32'd0);

        // Issue to 7, then writeback with bypass on port A.
        issue_valid = 1'b1; issue_index = 5'd7; rd_addr_a = 5'd7;
        checkOutput("ready_7", {31'b0, issue_ready}, 32'd1);
        applyStimulus(1);
        checkOutput("busy7_issued", {31'b0, rd_busy_a}, 32'd1);
        issue_valid = 1'b0;
        wb_write = 1'b1; wb_index = 5'd7; wb_data = 32'hDEADBEEF;
        applyStimulus(1);
        checkOutput("bypass7_data", rd_data_a, 32'hDEADBEEF);
        checkOutput("bypass7_busy", {31'b0, rd_busy_a}, 32'd0);
        wb_write = 1'b0; rd_addr_b = 5'd7;
        applyStimulus(1);
        checkOutput("read7_a", rd_data_a, 32'hDEADBEEF);
        checkOutput("read7_b", rd_data_b, 32'hDEADBEEF);
        checkOutput("unexp_after7", {31'b0, wb_unexpected}, 32'd0);

        // Saturate register 3 with three issues; the fourth is refused.
        issue_valid = 1'b1; issue_index = 5'd3; rd_addr_a = 5'd3;
        applyStimulus(3);
        checkOutput("ready3_sat", {31'b0, issue_ready}, 32'd0);
        applyStimulus(1);
        checkOutput("busy3_after4th", {31'b0, rd_busy_a}, 32'd1);
        issue_valid = 1'b0;
        wb_write = 1'b1; wb_index = 5'd3; wb_data = 32'h0000_0033;
        checkOutput("ready3_samecyc", {31'b0, issue_ready}, 32'd0);
        applyStimulus(1);
        checkOutput("ready3_freed", {31'b0, issue_ready}, 32'd1);
        checkOutput("busy3_cnt2", {31'b0, rd_busy_a}, 32'd1);
        applyStimulus(1);
        checkOutput("busy3_cnt1", {31'b0, rd_busy_a}, 32'd1);
        applyStimulus(1);
        checkOutput("busy3_cnt0", {31'b0, rd_busy_a}, 32'd0);
        checkOutput("unexp_after3", {31'b0, wb_unexpected}, 32'd0);
        wb_write = 1'b0;

        // Register 9: simultaneous issue and retire with one pending.
        issue_valid = 1'b1; issue_index = 5'd9; rd_addr_a = 5'd9;
        applyStimulus(1);
        wb_write = 1'b1; wb_index = 5'd9; wb_data = 32'h0000_0099;
        applyStimulus(1);
        checkOutput("both9_data", rd_data_a, 32'h0000_0099);
        checkOutput("both9_busy", {31'b0, rd_busy_a}, 32'd1);
        issue_valid = 1'b0; wb_write = 1'b0;
        applyStimulus(1);
        checkOutput("read9_data", rd_data_a, 32'h0000_0099);
        checkOutput("read9_busy", {31'b0, rd_busy_a}, 32'd1);
        wb_write = 1'b1;
        applyStimulus(1);
        checkOutput("busy9_clear", {31'b0, rd_busy_a}, 32'd0);
        wb_write = 1'b0;

        // Register 20: retire with zero pending but a same-cycle issue is not unexpected.
        issue_valid = 1'b1; issue_index = 5'd20;
        wb_write = 1'b1; wb_index = 5'd20; wb_data = 32'h0000_2020; rd_addr_a = 5'd20;
        applyStimulus(1);
        checkOutput("unexp20_none", {31'b0, wb_unexpected}, 32'd0);
        checkOutput("busy20_one", {31'b0, rd_busy_a}, 32'd1);
        issue_valid = 1'b0;
        applyStimulus(1);
        checkOutput("busy20_clear", {31'b0, rd_busy_a}, 32'd0);
        checkOutput("unexp20_still", {31'b0, wb_unexpected}, 32'd0);
        wb_write = 1'b0;

        // Writes to register 0 are ignored.
        wb_write = 1'b1; wb_index = 5'd0; wb_data = 32'h0000_1234; rd_addr_a = 5'd0;
        applyStimulus(1);
        checkOutput("r0_bypass", rd_data_a, 32'd0);
        wb_write = 1'b0;
        applyStimulus(1);
        checkOutput("r0_read", rd_data_a, 32'd0);
        checkOutput("r0_unexp", {31'b0, wb_unexpected}, 32'd0);

        // Unexpected writeback to 12 sets the sticky flag but still writes.
        wb_write = 1'b1; wb_index = 5'd12; wb_data = 32'hC0FF_EE12; rd_addr_b = 5'd12;
        applyStimulus(1);
        checkOutput("unexp12_set", {31'b0, wb_unexpected}, 32'd1);
        checkOutput("unexp12_data", rd_data_b, 32'hC0FF_EE12);
        checkOutput("unexp12_busy", {31'b0, rd_busy_b}, 32'd0);
        wb_write = 1'b0;
        applyStimulus(1);
        checkOutput("unexp12_sticky", {31'b0, wb_unexpected}, 32'd1);
        checkOutput("read12", rd_data_b, 32'hC0FF_EE12);

        // Two pending on 4, then reset with concurrent issue and writeback.
        issue_valid = 1'b1; issue_index = 5'd4; rd_addr_a = 5'd4;
        applyStimulus(2);
        issue_valid = 1'b0;
        applyStimulus(1);
        checkOutput("busy4_pending", {31'b0, rd_busy_a}, 32'd1);
        rst = 1'b1; issue_valid = 1'b1; wb_write = 1'b1; wb_index = 5'd4; wb_data = 32'h0000_0044;
        applyStimulus(1);
        rst = 1'b0; issue_valid = 1'b0; wb_write = 1'b0;
        checkOutput("mid_rst_data_b", rd_data_b, 32'd0);
        checkOutput("mid_rst_busy_a", {31'b0, rd_busy_a}, 32'd0);
        checkOutput("mid_rst_unexp", {31'b0, wb_unexpected}, 32'd0);
        applyStimulus(1);
        checkOutput("post_rst_read4", rd_data_a, 32'd0);
        checkOutput("post_rst_busy4", {31'b0, rd_busy_a}, 32'd0);
        checkOutput("post_rst_read12", rd_data_b, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Register file at the far end of the writeback interface: consumes the per-cycle (index, data, write-strobe) triple that writeback drives.
- Provides two registered read ports with same-cycle write bypass, for decode/operand fetch.
- Keeps a per-register pending-write scoreboard. Issue marks a destination pending; writeback retires it. Decode uses the busy flags to detect RAW hazards.

Parameters:
- DATA_W, 32, register data width.
- PEND_W, 2, width of each per-register pending-write counter; max outstanding writes per register = 2^PEND_W - 1.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wb_index  input  5  destination register from writeback.
- wb_data  input  DATA_W  write data from writeback.
- wb_write  input  1  write strobe from writeback.
- issue_valid  input  1  an instruction with a destination register is issuing.
- issue_index  input  5  destination of the issuing instruction.
- issue_ready  output  1  combinational: the pending counter for issue_index is not saturated.
- rd_addr_a  input  5  read port A address.
- rd_addr_b  input  5  read port B address.
- rd_data_a  output  DATA_W  read port A data, registered.
- rd_data_b  output  DATA_W  read port B data, registered.
- rd_busy_a  output  1  port A register has pending writes, registered.
- rd_busy_b  output  1  port B register has pending writes, registered.
- wb_unexpected  output  1  sticky: a writeback arrived for a register with zero pending.

Behaviour:
- Reset (rst=1 at edge):
  - all 32 registers go to 0 and all pending counters go to 0.
  - rd_data_a/b, rd_busy_a/b and wb_unexpected go to 0.
  - reset overrides any simultaneous wb_write or issue; in-flight scoreboard state is discarded.
- Register 0:
  - always reads 0 and is never busy.
  - writes to it are ignored.
  - issue with index 0 always has issue_ready=1 and has no effect.
- Write:
  - when wb_write=1 and wb_index!=0, regs[wb_index] <= wb_data at the edge.
  - the write is unconditional on scoreboard state.
- Read:
  - latency is 1 cycle; rd_data_x at cycle N+1 reflects rd_addr_x sampled at edge N.
  - if wb_write=1 and wb_index==rd_addr_x!=0 in the same cycle, rd_data_x <= wb_data (write-first bypass).
  - otherwise rd_data_x <= regs[rd_addr_x].
- Scoreboard, per register r!=0, counter cnt[r]:
  - inc = issue_valid && issue_ready && issue_index==r.
  - dec = wb_write && wb_index==r && cnt[r]!=0.
  - inc only: cnt+1. dec only: cnt-1. both or neither: unchanged.
- issue_ready = (issue_index==0) || cnt[issue_index] != 2^PEND_W-1.
  - computed from current-cycle state; a same-cycle dec does not free a slot.
  - issue_valid while issue_ready=0 is not recorded; the issuer must hold and retry.
- Busy:
  - rd_busy_x <= (next-state cnt[rd_addr_x] != 0), i.e. after this cycle's inc/dec.
  - rd_busy_x is always 0 for address 0.
- wb_unexpected:
  - set at the edge where wb_write=1, wb_index!=0 and cnt[wb_index]==0 with no same-cycle inc to that index.
  - cleared only by reset.
  - the data is still written and the counter stays at 0 (no underflow).
- Port A and port B reading the same register both receive identical data and busy.

Test Plan:
- Reset, then read addrs 0 and 5 -> next cycle rd_data 0/0, rd_busy 0/0, wb_unexpected 0.
- Issue idx 7, next cycle wb_write idx 7 data 0xDEADBEEF while rd_addr_a=7:
  - -> rd_data_a=0xDEADBEEF (bypass) and rd_busy_a=0 one cycle later.
  - -> a later read of 7 also returns 0xDEADBEEF.
- Issue idx 3 three times (PEND_W=2):
  - -> issue_ready=0 on the 4th attempt.
  - -> one writeback to 3 gives issue_ready=1 next cycle.
  - -> rd_busy stays 1 until the third writeback.
- Same cycle: issue idx 9 plus wb_write idx 9 with cnt[9]=1 -> cnt stays 1, rd_busy for 9 = 1, data written.
- wb_write idx 0 data 0x1234 -> read 0 returns 0; wb_write idx 12 with no issue -> wb_unexpected=1 and regs[12] updated.
- Two pending on idx 4, assert rst mid-operation -> cnt cleared, rd_busy 0, reads return 0.
